receiver: RTL and testbench

Serial-to-parallel receiver for the single-wire, one-bit-per-clock UART link driven by `transmitter`. It sits on the far end of the wire (`u_tx` → `u_rx`) and deframes start, 8 data bits LSB-first, even parity and guard bit. It presents each byte on a registered valid/ready output toward the main bus, with parity-error and overrun flags. Line and both ends share `clk`; no baud divider.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/receiver.sv | 123 ++++++++++++
 tb/tb_receiver.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by both ends of the one-bit-per-clock UART link.
//   - UART_DATA_W      : data bits per frame (the link carries 8 only)
//   - rx_state_t       : receiver FSM encodings, placed above the transmitter's
//                        codes (0..3) so both fit one 3-bit state space
//   - uart_even_parity : even-parity bit of a data byte
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd4,
        RX_DATA   = 3'd5,
        RX_PARITY = 3'd6,
        RX_GUARD  = 3'd7
    } rx_state_t;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic uart_even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/receiver.sv
// receiver: serial-to-parallel deframer for the single-wire UART link.
// Frame, one bit per clock: start(0), d0..d7 LSB first, even parity, guard(0).
// Line and receiver share clk; the line is sampled on the rising edge.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   u_rx       in   serial line (idle is z or 1)
//   rx_ready   in   consumer accepts rx_data when rx_valid & rx_ready
//   rx_data    out  received byte, held while rx_valid
//   rx_valid   out  byte available
//   rx_perr    out  parity error for the byte in rx_data
//   rx_overrun out  one-cycle pulse: an unaccepted byte was overwritten
//   rx_busy    out  FSM is not in IDLE
module receiver
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              u_rx,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_perr,
    output logic              rx_overrun,
    output logic              rx_busy
);

    localparam int CNT_W = $clog2(DATA_W);

    rx_state_t          r_state;
    rx_state_t          w_next;
    logic [CNT_W-1:0]   r_count;
    logic [DATA_W-1:0]  r_shift;
    logic               w_bit;
    logic               w_start;
    logic               w_load;
    logic               w_perr;

    // Only a driven 0 starts a frame and only a driven 1 counts as a one;
    // a floating or unknown line reads as "not a start" / "zero".
    assign w_bit   = (u_rx === 1'b1);
    assign w_start = (u_rx === 1'b0);

    // Shift register is complete by the parity cycle, so the parity bit on
    // the line closes the even-parity check directly.
    assign w_perr = uart_even_parity(r_shift) ^ w_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (w_start) begin
                    w_next = RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_count == CNT_W'(DATA_W - 1)) begin
                    w_next = RX_PARITY;
                end
            end
            RX_PARITY: begin
                w_load = 1'b1;
                w_next = RX_GUARD;
            end
            RX_GUARD: begin
                w_next = RX_IDLE;
            end
            default: begin
                w_next = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_shift <= '0;
        end else begin
            if (r_state == RX_IDLE && w_start) begin
                r_count <= '0;
            end else if (r_state == RX_DATA) begin
                r_shift[r_count] <= w_bit;
                r_count          <= r_count + 1'b1;
            end
        end
    end

    // Output holding register. A load always wins; a pending byte that was
    // not taken on the same edge is lost and flagged with a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_perr    <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (w_load) begin
                rx_data    <= r_shift;
                rx_perr    <= w_perr;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid & ~rx_ready;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_busy = (r_state != RX_IDLE);

endmodule

// File: tb/tb_receiver.sv
// tb_receiver: directed bench for receiver. Frames are driven on the falling
// edge like the transmitter; outputs are sampled on the falling edge. Each
// driven frame pushes its expected byte/parity-error to a scoreboard queue
// that is popped at the cycle after the parity sample.
`timescale 1ns/1ps
module tb_receiver;
    import uart_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       rx_ready;
    logic       r_oe;
    logic       r_bit;
    wire        w_line;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_perr;
    logic       rx_overrun;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];
    logic       m_valid;

    assign w_line = r_oe ? r_bit : 1'bz;
    pullup (w_line);

    receiver #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .u_rx       (w_line),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_perr    (rx_perr),
        .rx_overrun (rx_overrun),
        .rx_busy    (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle with no load expected at the edge just taken.
    task automatic tick();
        @(negedge clk);
        if (rx_ready) m_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            r_oe  = 1'b1;
            r_bit = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit);
        logic [10:0] bits;
        logic [8:0]  exp;
        logic        exp_ovr;
        bits = {1'b0, pbit, d, 1'b0};
        sb.push_back({^{d, pbit}, d});
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 10) begin
                // Edge just taken is the parity sample: the load happens here.
                exp_ovr = m_valid && !rx_ready;
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd0, 32'd1);
                end else begin
                    exp = sb.pop_front();
                    chk("valid", rx_valid, 1);
                    chk("data", rx_data, exp[7:0]);
                    chk("perr", rx_perr, exp[8]);
                    chk("overrun", rx_overrun, exp_ovr);
                end
                m_valid = 1'b1;
            end else begin
                if (rx_ready) m_valid = 1'b0;
                if (i == 0 && rx_ready) chk("valid_cleared", rx_valid, 0);
                if (i == 1) chk("busy", rx_busy, 1);
                if (i == 9 && !m_valid) chk("valid_early", rx_valid, 0);
            end
            r_oe  = 1'b1;
            r_bit = bits[i];
        end
    endtask

    initial begin
        logic [10:0] fb;
        rst_n    = 1'b0;
        rx_ready = 1'b1;
        r_oe     = 1'b1;
        r_bit    = 1'b1;
        m_valid  = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_data", rx_data, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_perr", rx_perr, 0);
        chk("rst_overrun", rx_overrun, 0);
        chk("rst_busy", rx_busy, 0);
        rst_n = 1'b1;
        idle(3);

        // Clean frame, good parity.
        send_frame(8'hA5, uart_even_parity(8'hA5));
        idle(3);

        // Parity bit forced to 0 on a byte whose parity is 1.
        send_frame(8'h01, 1'b0);
        idle(3);

        // Back-to-back frames, 11-cycle period.
        send_frame(8'h3C, uart_even_parity(8'h3C));
        send_frame(8'hC3, uart_even_parity(8'hC3));
        idle(3);

        // Consumer stalled: second byte overwrites the first.
        rx_ready = 1'b0;
        send_frame(8'h11, uart_even_parity(8'h11));
        send_frame(8'h22, uart_even_parity(8'h22));
        tick();
        r_bit = 1'b1;
        chk("overrun_one_cycle", rx_overrun, 0);
        chk("held_valid", rx_valid, 1);
        chk("held_data", rx_data, 8'h22);
        rx_ready = 1'b1;
        tick();
        chk("accept_clears", rx_valid, 0);
        idle(3);

        // Reset in the middle of frame 0x5A.
        fb = {1'b0, uart_even_parity(8'h5A), 8'h5A, 1'b0};
        for (int i = 0; i < 5; i++) begin
            tick();
            r_bit = fb[i];
        end
        @(negedge clk);
        rst_n = 1'b0;
        m_valid = 1'b0;
        #1;
        chk("midrst_busy", rx_busy, 0);
        chk("midrst_valid", rx_valid, 0);
        for (int i = 5; i < 11; i++) begin
            @(negedge clk);
            r_bit = fb[i];
        end
        @(negedge clk);
        r_bit = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        chk("postrst_valid", rx_valid, 0);
        chk("postrst_busy", rx_busy, 0);
        send_frame(8'h96, uart_even_parity(8'h96));
        idle(3);

        // Undriven line, then driven idle: never starts a frame.
        r_oe = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            chk("z_busy", rx_busy, 0);
            chk("z_valid", rx_valid, 0);
        end
        r_oe  = 1'b1;
        r_bit = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            chk("one_busy", rx_busy, 0);
            chk("one_valid", rx_valid, 0);
        end

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog: the directed sequence is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

endmodule
